// File: rtl/i2c_pkg.sv
// Shared I2C definitions: master FSM states, known slave addresses, R/W bit encodings.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    DATA_W,
    DATA_R,
    DATA_ACK,
    STOP
  } i2c_state_t;

  localparam logic [6:0] FIFO_SLAVE_ADDR = 7'b0011001;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_clk_gen.sv
// SCL quarter-period timebase: one-clk tick every CLK_DIV clk plus a 2-bit quarter index.
// Held at zero while disabled; stall freezes both counters so the current quarter stretches.
module i2c_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       stall,
  output logic       tick,
  output logic [1:0] quarter
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && !stall && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      quarter <= '0;
    end else if (!en) begin
      cnt     <= '0;
      quarter <= '0;
    end else if (!stall) begin
      if (cnt == CNT_MAX) begin
        cnt     <= '0;
        quarter <= quarter + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C master: START, addr+R/W, one byte, STOP; done 80*CLK_DIV+1 clk after start.
// New starts are ignored while busy; I2C_MASTER_CLK_STRETCH_EN lets a slave hold SCL low in Q2.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  input  logic       SDA_I,
  input  logic       SCL_I,
  output logic       SDA_O,
  output logic       SCL_O,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata
);

  i2c_state_t state, state_n;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] tx_byte, tx_n, rx_sh, rx_n, wdata_q, wdata_n, rdata_n;
  logic       rw_q, rw_n, busy_n, done_n, ack_err_n, scl_n, sda_n;
  logic       tick, stall, sample, slot_end;
  logic [1:0] quarter, quarter_n;

`ifdef I2C_MASTER_CLK_STRETCH_EN
  assign stall = (quarter == 2'd2) && SCL_O && !SCL_I;
`else
  logic unused_scl_i;
  assign unused_scl_i = SCL_I;
  assign stall        = 1'b0;
`endif

  i2c_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk     (clk),
    .rst     (rst),
    .en      (state != IDLE),
    .stall   (stall),
    .tick    (tick),
    .quarter (quarter)
  );

  assign sample    = tick && (quarter == 2'd2);
  assign slot_end  = tick && (quarter == 2'd3);
  assign quarter_n = tick ? quarter + 2'd1 : quarter;

  always_comb begin
    state_n   = state;
    bit_n     = bit_cnt;
    tx_n      = tx_byte;
    rx_n      = rx_sh;
    rw_n      = rw_q;
    wdata_n   = wdata_q;
    busy_n    = busy;
    done_n    = 1'b0;
    ack_err_n = ack_err;
    rdata_n   = rdata;
    case (state)
      IDLE: if (start) begin
        state_n   = START;
        rw_n      = rw;
        wdata_n   = wdata;
        tx_n      = {addr, rw};
        busy_n    = 1'b1;
        ack_err_n = 1'b0;
      end
      START: if (slot_end) begin
        state_n = ADDR;
        bit_n   = 3'd7;
      end
      ADDR, DATA_W, DATA_R: begin
        if (sample && state == DATA_R) rx_n = {rx_sh[6:0], SDA_I};
        if (slot_end) begin
          bit_n = bit_cnt - 3'd1;
          if (bit_cnt == 3'd0) state_n = (state == ADDR) ? ADDR_ACK : DATA_ACK;
        end
      end
      ADDR_ACK: begin
        if (sample && SDA_I) ack_err_n = 1'b1;
        if (slot_end) begin
          bit_n = 3'd7;
          if (ack_err)               state_n = STOP;
          else if (rw_q == RW_READ)  state_n = DATA_R;
          else begin
            state_n = DATA_W;
            tx_n    = wdata_q;
          end
        end
      end
      DATA_ACK: begin
        // On a read the master leaves SDA released here, which is the closing NACK.
        if (sample && rw_q == RW_WRITE && SDA_I) ack_err_n = 1'b1;
        if (slot_end) state_n = STOP;
      end
      STOP: if (slot_end) begin
        state_n = IDLE;
        busy_n  = 1'b0;
        done_n  = 1'b1;
        if (rw_q == RW_READ && !ack_err) rdata_n = rx_sh;
      end
      default: state_n = IDLE;
    endcase

    // Bus lines are registered from the upcoming state/quarter so they switch exactly on quarter edges.
    scl_n = 1'b1;
    sda_n = 1'b1;
    case (state_n)
      START:                      sda_n = ~quarter_n[1];
      ADDR, DATA_W: begin
        scl_n = quarter_n[1];
        sda_n = tx_n[bit_n];
      end
      ADDR_ACK, DATA_R, DATA_ACK: scl_n = quarter_n[1];
      STOP: begin
        scl_n = (quarter_n != 2'd0);
        sda_n = quarter_n[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= 3'd7;
      tx_byte <= '0;
      rx_sh   <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      rdata   <= '0;
      SCL_O   <= 1'b1;
      SDA_O   <= 1'b1;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_n;
      tx_byte <= tx_n;
      rx_sh   <= rx_n;
      wdata_q <= wdata_n;
      rw_q    <= rw_n;
      busy    <= busy_n;
      done    <= done_n;
      ack_err <= ack_err_n;
      rdata   <= rdata_n;
      SCL_O   <= scl_n;
      SDA_O   <= sda_n;
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Scoreboard bench for i2c_master: bus-level slave model, queued expectations, randomized transactions.
`timescale 1ns/1ps
module tb_i2c_master;
  import i2c_pkg::*;

  localparam int CLK_DIV  = 2;
  localparam int SLOT_CLK = 4 * CLK_DIV;

  logic       clk = 1'b0, rst = 1'b0, start = 1'b0, rw = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       SDA_I, SCL_I, SDA_O, SCL_O, busy, done, ack_err;
  logic [7:0] rdata;

  always #5 clk = ~clk;

  // Open-drain bus: the line is low if either side pulls it low.
  logic slv_sda = 1'b1, scl_hold = 1'b0;
  assign SDA_I = SDA_O & slv_sda;
  assign SCL_I = SCL_O & ~scl_hold;

  i2c_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .SDA_I(SDA_I), .SCL_I(SCL_I), .SDA_O(SDA_O), .SCL_O(SCL_O),
    .busy(busy), .done(done), .ack_err(ack_err), .rdata(rdata)
  );

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- slave model (FIFO slave at FIFO_SLAVE_ADDR) ----------------
  logic       sl_active = 1'b0, sl_mack = 1'b0, slv_wack = 1'b1, stretch_req = 1'b0;
  int         sl_cnt = 0;
  logic [7:0] sl_addr_byte = '0, sl_data_byte = '0, slv_byte = '0;
  event       hold_ev;

  always @(negedge SDA_I) if (SCL_O) begin sl_active = 1'b1; sl_cnt = 0; end
  always @(posedge SDA_I) if (SCL_O) sl_active = 1'b0;

  always @(posedge SCL_O) if (sl_active) begin
    if (sl_cnt < 8)                      sl_addr_byte = {sl_addr_byte[6:0], SDA_I};
    else if (sl_cnt >= 9 && sl_cnt <= 16) sl_data_byte = {sl_data_byte[6:0], SDA_I};
    else if (sl_cnt == 17)               sl_mack = SDA_I;
    if (stretch_req && sl_cnt == 4) begin
      stretch_req = 1'b0;
      scl_hold    = 1'b1;
      ->hold_ev;
    end
    sl_cnt++;
  end

  always @(hold_ev) begin
    repeat (11) @(negedge clk);
    scl_hold = 1'b0;
  end

  always @(negedge SCL_O) begin
    logic acked;
    acked   = (sl_addr_byte[7:1] == FIFO_SLAVE_ADDR);
    slv_sda = 1'b1;
    if (sl_active) begin
      if (sl_cnt == 8 && acked)                                slv_sda = 1'b0;
      else if (sl_cnt >= 9 && sl_cnt <= 16 && acked && sl_addr_byte[0]) slv_sda = slv_byte[16 - sl_cnt];
      else if (sl_cnt == 17 && acked && !sl_addr_byte[0] && slv_wack)   slv_sda = 1'b0;
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int         t_issue;
    int         lat;
    logic       ack_err;
    logic [7:0] rdata;
    logic [7:0] abyte;
    logic       has_data;
    logic [7:0] dbyte;
    logic       is_read;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_rdata = '0;

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 5000) begin @(negedge clk); n++; end
    chk("idle_timeout", {31'd0, busy}, 0);
  endtask

  task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] wd,
                       input logic [7:0] sb, input logic wack, input logic str);
    exp_t e;
    logic ok;
    wait_idle();
    slv_byte    = sb;
    slv_wack    = wack;
    stretch_req = str;
    ok          = (a == FIFO_SLAVE_ADDR);
    e.abyte     = {a, r};
    e.has_data  = ok;
    e.dbyte     = r ? sb : wd;
    e.is_read   = r && ok;
    e.ack_err   = !ok || (!r && !wack);
    if (ok && r) model_rdata = sb;
    e.rdata     = model_rdata;
    e.lat       = (ok ? 20 : 11) * SLOT_CLK + 1 + (str ? 10 : 0);
    e.t_issue   = cyc;
    exp_q.push_back(e);
    start = 1'b1; addr = a; rw = r; wdata = wd;
    @(negedge clk);
    start = 1'b0; addr = 7'($urandom); rw = 1'($urandom); wdata = 8'($urandom);
    chk("busy_after_accept", {31'd0, busy}, 1);
  endtask

  always @(negedge clk) if (rst && done) begin
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_done", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("latency", cyc - e.t_issue, e.lat);
      chk("ack_err", {31'd0, ack_err}, {31'd0, e.ack_err});
      chk("rdata", {24'd0, rdata}, {24'd0, e.rdata});
      chk("busy_with_done", {31'd0, busy}, 0);
      chk("bus_addr_byte", {24'd0, sl_addr_byte}, {24'd0, e.abyte});
      if (e.has_data) chk("bus_data_byte", {24'd0, sl_data_byte}, {24'd0, e.dbyte});
      if (e.is_read)  chk("master_nack", {31'd0, sl_mack}, 1);
    end
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_scl", {31'd0, SCL_O}, 1);
    chk("rst_sda", {31'd0, SDA_O}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_ack_err", {31'd0, ack_err}, 0);
    chk("rst_rdata", {24'd0, rdata}, 0);
    rst = 1'b1;

    issue(FIFO_SLAVE_ADDR, RW_WRITE, 8'hA5, 8'h00, 1'b1, 1'b0);
    issue(FIFO_SLAVE_ADDR, RW_READ,  8'h00, 8'h3C, 1'b1, 1'b0);
    issue(7'h7F,           RW_WRITE, 8'h5A, 8'h00, 1'b1, 1'b0);

    // A second start while busy must be dropped.
    issue(FIFO_SLAVE_ADDR, RW_WRITE, 8'h11, 8'h00, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    start = 1'b1; addr = FIFO_SLAVE_ADDR; rw = RW_WRITE; wdata = 8'hEE;
    @(negedge clk);
    start = 1'b0;

    // Reset in the second data-bit slot of a write, while SCL and SDA are low.
    issue(FIFO_SLAVE_ADDR, RW_WRITE, 8'h00, 8'h00, 1'b1, 1'b0);
    repeat (11 * SLOT_CLK) @(negedge clk);
    chk("mid_scl_low", {31'd0, SCL_O}, 0);
    rst = 1'b0;
    #1;
    chk("arst_scl", {31'd0, SCL_O}, 1);
    chk("arst_sda", {31'd0, SDA_O}, 1);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_rdata", {24'd0, rdata}, 0);
    void'(exp_q.pop_back());
    model_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    issue(FIFO_SLAVE_ADDR, RW_READ, 8'h00, 8'hC3, 1'b1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      logic [6:0] a;
      a = ($urandom_range(0, 2) != 0) ? FIFO_SLAVE_ADDR : 7'($urandom);
      issue(a, 1'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
    end

`ifdef I2C_MASTER_CLK_STRETCH_EN
    issue(FIFO_SLAVE_ADDR, RW_WRITE, 8'h96, 8'h00, 1'b1, 1'b1);
    issue(FIFO_SLAVE_ADDR, RW_READ,  8'h00, 8'h69, 1'b1, 1'b1);
`endif

    wait_idle();
    repeat (4 * SLOT_CLK) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_master.md
# i2c_master

Single-byte I2C bus master that initiates transactions toward the bus slaves (FIFO slave and peers). It generates SCL from the system clock, issues START, 7-bit address plus R/W, one data byte and STOP, and checks slave ACKs. It sits between the system-side command logic and the split SDA/SCL bus lines, using separate in/out signals and no tristates.

## Interface
- CLK_DIV, 4: system clocks per SCL quarter-period, minimum 1; SCL period = 4*CLK_DIV clk.
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request; accepted only when busy=0.
- rw  in  1  1 = read, 0 = write; latched on accept.
- addr  in  7  target slave address; latched on accept.
- wdata  in  8  write byte; latched on accept.
- SDA_I  in  1  serial data from the bus (ACK and read data).
- SCL_I  in  1  bus clock readback; used only with clock stretching.
- SDA_O  out  1  serial data to the bus, MSB first.
- SCL_O  out  1  serial clock to the bus.
- busy  out  1  high from accept until done.
- done  out  1  one-cycle pulse at transaction end.
- ack_err  out  1  valid with done; 1 = address or write-data NACK.
- rdata  out  8  received byte; updated only on a successful read.

## Operation
- Reset values: SCL_O=1, SDA_O=1, busy=0, done=0, ack_err=0, rdata=0. Reset mid-transaction releases the bus immediately, with no STOP generated.
- States: IDLE, START, ADDR, ADDR_ACK, DATA_W, DATA_R, DATA_ACK, STOP.
- IDLE: on start, latch rw, addr, wdata, set busy, clear ack_err, and go to START. start while busy is ignored.
- START: SDA_O falls while SCL_O is high, then go to ADDR.
- ADDR: shift {addr, rw} over 8 bit slots, MSB first, then go to ADDR_ACK.
- ADDR_ACK: release SDA_O=1 and sample SDA_I.
  - SDA_I=1: set ack_err and go to STOP.
  - SDA_I=0 and rw=0: go to DATA_W.
  - SDA_I=0 and rw=1: go to DATA_R.
- DATA_W: shift wdata over 8 slots, then go to DATA_ACK, which samples SDA_I; a 1 there sets ack_err.
- DATA_R: hold SDA_O=1 and shift SDA_I into a shift register, MSB first. Then go to DATA_ACK, where the master drives NACK (SDA_O=1) to end the read.
- DATA_ACK always goes to STOP.
- STOP: SDA_O rises while SCL_O is high. On exit, pulse done, clear busy, return to IDLE, and load rdata on a read with no ack_err.
- Bit counter is 3 bits and counts 7 down to 0; the state advances when the count reaches 0.

## Timing
- Each bit slot has 4 quarters Q0..Q3, each CLK_DIV clk long, driven by a quarter tick.
- SCL_O=0 in Q0–Q1 and SCL_O=1 in Q2–Q3.
- SDA_O changes only at the start of Q0. SDA_I is sampled at the end of Q2.
- START slot: SCL_O=1 throughout; SDA_O=1 in Q0–Q1 and 0 in Q2–Q3.
- STOP slot: SDA_O=0 in Q0–Q1. SCL_O=0 in Q0 and 1 in Q1–Q3. SDA_O=1 in Q2–Q3.
- Transaction length is 20 slots (start, 8, ack, 8, ack, stop), i.e. 80*CLK_DIV clk from accept to done, plus 1 clk. A NACK on the address gives 11 slots.
- busy asserts the clk after start. done coincides with busy falling, and the next start is accepted the following clk.

## Configuration
- I2C_MASTER_CLK_STRETCH_EN defined: after raising SCL_O in Q2, the quarter counter freezes while SCL_I=0. It resumes when SCL_I=1, so the slot stretches.
- Not defined: SCL_I is ignored and timing is exact as above.

## Structure
- Shared package i2c_pkg holds:
  - state enum;
  - slave address constants (FIFO slave 7'b0011001);
  - R/W bit encodings.
- Sub-module i2c_clk_gen: the CLK_DIV counter that emits a one-clk quarter tick and the 2-bit quarter index, with a stall input for clock stretching.

## Test plan
- Write with CLK_DIV=2: addr=0x19, rw=0, wdata=0xA5, ACKing slave model → bus shows 0x32 then 0xA5. done comes 161 clk after start, with ack_err=0.
- Read with addr=0x19, rw=1; slave returns 0x3C → master sends NACK in the ack slot, then STOP; rdata=0x3C and ack_err=0.
- Address NACK: addr=0x7F, slave idle (SDA_I=1) → STOP right after the address ack slot; done comes at slot 11 with ack_err=1 and rdata unchanged.
- start pulsed while busy with a different wdata → original transaction completes unchanged and the second request is dropped.
- rst asserted mid-DATA_W → SCL_O=1, SDA_O=1, busy=0 immediately. A new start after reset release completes normally.
- Macro defined: slave holds SCL_I low for 10 clk in the ADDR bit-3 slot → that slot lengthens by 10 clk and the bus data stays correct.
